dma_dreq_requester: RTL and testbench
=====================================

# dma_dreq_requester

Peripheral-side DMA request engine for the 8237A-compatible controller. It generates the per-channel DREQ that feeds the controller's rotating-priority channel arbiter, and it consumes the returned DACK. It counts completed transfers, stops at its programmed terminal count or on an external EOP, and reports completion to the peripheral. One instance sits on each channel's peripheral port.

## Interface
- COUNT_W, 16, width of the transfer counter; the block performs xfer_count+1 transfers (8237 word-count convention)
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that arms a block of transfers; ignored unless state is IDLE
- xfer_count  in  COUNT_W  transfers minus one; sampled only when start is accepted
- demand_mode  in  1  0 = single mode, 1 = demand mode; sampled with start
- data_ready  in  1  peripheral can source or sink one transfer now
- dack  in  1  active-high DMA acknowledge from the controller; one high pulse per transfer
- eop_n  in  1  active-low end-of-process from the controller
- dreq  out  1  registered DMA request to the arbiter
- busy  out  1  high in REQ and ACK
- done  out  1  one-cycle pulse on completion, whether by count or by EOP
- eop_abort  out  1  sticky; set when EOP ended the block before terminal count; cleared by the next accepted start
- remaining  out  COUNT_W  transfers left minus one

## Operation
- States: IDLE, REQ, ACK, DONE. The state is one-hot internally.
- IDLE
  - Outputs: dreq=0, busy=0.
  - start=1 → remaining<=xfer_count, latch demand_mode, clear eop_abort, go to REQ.
- REQ
  - dreq follows data_ready through a register.
  - dack=1 → go to ACK.
  - dack while dreq=0 is still honored.
- ACK
  - Single mode: dreq<=0.
  - Demand mode: dreq<=data_ready.
  - dack falls (dack=0 sampled) → transfer complete:
    - remaining==0 → DONE.
    - otherwise remaining<=remaining-1 → REQ.
- DONE
  - One cycle: done=1, dreq=0, then IDLE.
  - remaining holds its final value, 0 on a normal finish.
- EOP
  - eop_n=0 sampled in REQ or ACK → DONE next cycle, dreq<=0.
  - eop_abort<=1 unless that same edge completes the last transfer.
  - If eop_n=0 and a dack fall occur on the same edge, the transfer is counted (remaining decrements if it is non-zero), then the block goes to DONE.
  - eop_n is ignored in IDLE and DONE.
- Boundaries
  - Decrement at remaining==0 never happens, so there is no wrap.
  - xfer_count=0 gives exactly one transfer.
  - xfer_count=all-ones gives 2^COUNT_W transfers.
  - dack in IDLE or DONE is ignored.
  - start while busy is ignored; nothing reloads.
- Reset (asynchronous, at any time including mid-transfer)
  - state=IDLE; dreq, busy, done, eop_abort all 0; remaining=0.
  - No done pulse on reset release.

## Timing
- start sampled at edge N → busy=1 after N. dreq=1 after N if data_ready=1 at N.
- dreq is registered: data_ready changes in REQ show on dreq one cycle later.
- dack=1 sampled at edge M → ACK after M. In single mode dreq=0 after M.
- dack=0 sampled at edge K (in ACK) → remaining updates after K; REQ or DONE after K.
- In single mode, dreq can re-assert after K, which gives at least one dreq-low cycle per transfer.
- Last dack fall at K → done=1 during cycle K+1 only; IDLE and busy=0 after K+1.
- eop_n=0 sampled at edge E → dreq=0 and done=1 during cycle E+1.
- Minimum transfer period in single mode is 2 cycles (dack high one cycle, low one cycle).

## Test plan
- Reset mid-block: reset=0 asynchronously while in ACK with remaining=5 → dreq, busy, done, eop_abort, remaining all 0 immediately; after release, state is IDLE and no done pulse.
- Single mode: xfer_count=3, data_ready=1, one-cycle dack pulses → exactly 4 transfers; dreq drops one cycle after each dack rise; remaining 3→2→1→0; one done pulse; eop_abort=0.
- Demand mode: xfer_count=2 with data_ready toggling 1,0,1 → dreq tracks data_ready one cycle late, stays high through ACK, and drops in DONE; 3 transfers; remaining=0.
- EOP abort: xfer_count=9, eop_n=0 after 4 transfers → done one cycle later; eop_abort=1; remaining=5; dreq=0. Next start clears eop_abort.
- Simultaneous events: eop_n=0 coincident with the dack fall on the final transfer (remaining=0) → eop_abort=0, single done pulse. start pulsed during busy → remaining not reloaded.
- Boundary: xfer_count=0 → exactly one transfer then done. COUNT_W=4 with xfer_count=15 → 16 transfers, no wrap.

Source files
------------

// File: rtl/dma_dreq_requester.sv
// Per-channel DMA request engine: raises DREQ toward the 8237 arbiter, counts
// DACK-completed transfers, and finishes on terminal count or external EOP.
module dma_dreq_requester #(
   parameter int unsigned COUNT_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [COUNT_W-1:0] xfer_count,
   input  logic               demand_mode,
   input  logic               data_ready,
   input  logic               dack,
   input  logic               eop_n,
   output logic               dreq,
   output logic               busy,
   output logic               done,
   output logic               eop_abort,
   output logic [COUNT_W-1:0] remaining
);

   typedef enum logic [3:0] {
      StIdle = 4'b0001,
      StReq  = 4'b0010,
      StAck  = 4'b0100,
      StDone = 4'b1000
   } state_e;

   state_e             state_q, state_d;
   logic               dreq_q, dreq_d;
   logic               demand_q, demand_d;
   logic               eop_abort_q, eop_abort_d;
   logic [COUNT_W-1:0] remaining_q, remaining_d;
   logic               last_xfer;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         dreq_q      <= 1'b0;
         demand_q    <= 1'b0;
         eop_abort_q <= 1'b0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         dreq_q      <= dreq_d;
         demand_q    <= demand_d;
         eop_abort_q <= eop_abort_d;
         remaining_q <= remaining_d;
      end
   end

   // The final transfer completes on the dack fall seen while the count is already zero.
   assign last_xfer = (state_q == StAck) && !dack && (remaining_q == '0);

   always_comb begin
      state_d     = state_q;
      dreq_d      = 1'b0;
      demand_d    = demand_q;
      eop_abort_d = eop_abort_q;
      remaining_d = remaining_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               remaining_d = xfer_count;
               demand_d    = demand_mode;
               eop_abort_d = 1'b0;
               dreq_d      = data_ready;
               state_d     = StReq;
            end
         end
         StReq: begin
            if (dack) begin
               dreq_d  = demand_q & data_ready;
               state_d = StAck;
            end else begin
               dreq_d = data_ready;
            end
         end
         StAck: begin
            if (!dack) begin
               if (remaining_q == '0) begin
                  state_d = StDone;
               end else begin
                  remaining_d = remaining_q - COUNT_W'(1);
                  dreq_d      = data_ready;
                  state_d     = StReq;
               end
            end else begin
               dreq_d = demand_q & data_ready;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // EOP overrides everything once any coincident transfer has been counted.
      if (!eop_n && ((state_q == StReq) || (state_q == StAck))) begin
         state_d = StDone;
         dreq_d  = 1'b0;
         if (!last_xfer) begin
            eop_abort_d = 1'b1;
         end
      end
   end

   assign dreq      = dreq_q;
   assign busy      = (state_q == StReq) || (state_q == StAck);
   assign done      = (state_q == StDone);
   assign eop_abort = eop_abort_q;
   assign remaining = remaining_q;

endmodule

// File: tb/tb_dma_dreq_requester.sv
// Randomised and directed bench for dma_dreq_requester (16-bit and 4-bit counters)
// checked every cycle against a transfer-level reference model.
module tb_dma_dreq_requester;

   logic        clock;
   logic        reset;
   logic        start;
   logic [15:0] xfer_count;
   logic [3:0]  xfer_count4;
   logic        demand_mode;
   logic        data_ready;
   logic        dack;
   logic        eop_n;
   logic        dreq16, busy16, done16, abort16;
   logic [15:0] rem16;
   logic        dreq4, busy4, done4, abort4;
   logic [3:0]  rem4;

   int unsigned n_pass, n_total, done_cnt16, done_cnt4;

   assign xfer_count4 = xfer_count[3:0];

   dma_dreq_requester #(.COUNT_W(16)) dut16 (
      .clock(clock), .reset(reset), .start(start), .xfer_count(xfer_count),
      .demand_mode(demand_mode), .data_ready(data_ready), .dack(dack), .eop_n(eop_n),
      .dreq(dreq16), .busy(busy16), .done(done16), .eop_abort(abort16), .remaining(rem16)
   );

   dma_dreq_requester #(.COUNT_W(4)) dut4 (
      .clock(clock), .reset(reset), .start(start), .xfer_count(xfer_count4),
      .demand_mode(demand_mode), .data_ready(data_ready), .dack(dack), .eop_n(eop_n),
      .dreq(dreq4), .busy(busy4), .done(done4), .eop_abort(abort4), .remaining(rem4)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Transfer-level view: a block is running, a transfer may be in flight
   // (acknowledged but not yet released), and a finished block announces itself once.
   typedef struct packed {
      bit          running;
      bit          in_xfer;
      bit          finishing;
      bit          demand;
      bit          abort;
      bit          dreq;
      logic [31:0] left;
   } model_t;

   model_t m16, m4;

   function automatic model_t step(input model_t m, input bit s, input logic [31:0] xc,
                                   input bit dm, input bit dr, input bit dk, input bit en);
      model_t n = m;
      bit complete, last;
      if (m.finishing) begin
         n.finishing = 1'b0;
         n.dreq      = 1'b0;
      end else if (!m.running) begin
         n.dreq = 1'b0;
         if (s) begin
            n.running = 1'b1;
            n.in_xfer = 1'b0;
            n.left    = xc;
            n.demand  = dm;
            n.abort   = 1'b0;
            n.dreq    = dr;
         end
      end else begin
         complete = m.in_xfer && !dk;
         last     = complete && (m.left == 0);
         if (complete && m.left != 0) n.left = m.left - 1;
         if (!en || last) begin
            n.running   = 1'b0;
            n.finishing = 1'b1;
            n.in_xfer   = 1'b0;
            n.dreq      = 1'b0;
            if (!en && !last) n.abort = 1'b1;
         end else if (complete) begin
            n.in_xfer = 1'b0;
            n.dreq    = dr;
         end else if (m.in_xfer || dk) begin
            n.in_xfer = 1'b1;
            n.dreq    = m.demand & dr;
         end else begin
            n.dreq = dr;
         end
      end
      return n;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   task automatic compare();
      check("model16", {12'b0, dreq16, busy16, done16, abort16, rem16},
            {12'b0, m16.dreq, m16.running, m16.finishing, m16.abort, m16.left[15:0]});
      check("model4", {24'b0, dreq4, busy4, done4, abort4, rem4},
            {24'b0, m4.dreq, m4.running, m4.finishing, m4.abort, m4.left[3:0]});
      if (done16) done_cnt16++;
      if (done4) done_cnt4++;
   endtask

   // Drive inputs for one cycle, advance the model on the edge, compare at the next negedge.
   task automatic cyc(input bit s, input logic [31:0] xc, input bit dm, input bit dr,
                      input bit dk, input bit en);
      start = s; xfer_count = xc[15:0]; demand_mode = dm;
      data_ready = dr; dack = dk; eop_n = en;
      @(posedge clock);
      m16 = step(m16, s, xc & 32'hFFFF, dm, dr, dk, en);
      m4  = step(m4,  s, xc & 32'hF,    dm, dr, dk, en);
      @(negedge clock);
      compare();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check("reset_outputs16", {dreq16, busy16, done16, abort16, rem16}, '0);
      check("reset_outputs4", {dreq4, busy4, done4, abort4, rem4}, '0);
      m16 = '0;
      m4  = '0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      n_pass = 0; n_total = 0; done_cnt16 = 0; done_cnt4 = 0;
      m16 = '0; m4 = '0;
      reset = 1'b0; start = 1'b0; xfer_count = '0; demand_mode = 1'b0;
      data_ready = 1'b0; dack = 1'b0; eop_n = 1'b1;
      #1;
      check("por_state", {dreq16, busy16, done16, abort16, rem16}, '0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      cyc(0, 0, 0, 0, 0, 1);

      // Single mode, four transfers.
      done_cnt16 = 0;
      cyc(1, 3, 0, 1, 0, 1);
      check("single_arm", {30'b0, dreq16, busy16}, 32'd3);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 1, 1, 1);
         check("single_dreq_drop", {31'b0, dreq16}, 0);
         cyc(0, 0, 0, 1, 0, 1);
         check("single_remaining", {16'b0, rem16}, (i < 3) ? 32'(2 - i) : 32'd0);
      end
      cyc(0, 0, 0, 1, 0, 1);
      check("single_done_count", done_cnt16, 1);
      check("single_abort", {31'b0, abort16}, 0);

      // Demand mode, dreq tracks data_ready one cycle late and holds through ACK.
      cyc(1, 2, 1, 1, 0, 1);
      cyc(0, 0, 1, 0, 0, 1);
      check("demand_track_low", {31'b0, dreq16}, 0);
      cyc(0, 0, 1, 1, 0, 1);
      check("demand_track_high", {31'b0, dreq16}, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 1, 1, 1);
         check("demand_hold_in_ack", {31'b0, dreq16}, 1);
         cyc(0, 0, 1, 1, 0, 1);
      end
      check("demand_done", {29'b0, dreq16, done16, |rem16}, 32'b010);
      cyc(0, 0, 1, 1, 0, 1);

      // EOP abort after four of ten transfers.
      cyc(1, 9, 0, 1, 0, 1);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 1, 1, 1);
         cyc(0, 0, 0, 1, 0, 1);
      end
      cyc(0, 0, 0, 1, 0, 0);
      check("eop_done", {13'b0, dreq16, done16, abort16, rem16}, {13'b0, 3'b011, 16'd5});
      cyc(0, 0, 0, 1, 0, 1);
      check("eop_abort_sticky", {31'b0, abort16}, 1);
      cyc(1, 0, 0, 1, 0, 1);
      check("eop_abort_cleared", {31'b0, abort16}, 0);
      cyc(0, 0, 0, 1, 1, 1);
      cyc(0, 0, 0, 1, 0, 1);
      cyc(0, 0, 0, 1, 0, 1);

      // EOP coincident with the final dack fall is a normal finish.
      done_cnt16 = 0;
      cyc(1, 0, 0, 1, 0, 1);
      cyc(0, 0, 0, 1, 1, 1);
      cyc(0, 0, 0, 1, 0, 0);
      check("coincident_eop", {30'b0, done16, abort16}, 32'b10);
      cyc(0, 0, 0, 1, 0, 1);
      check("coincident_single_done", done_cnt16, 1);

      // Start while busy does not reload.
      cyc(1, 5, 0, 1, 0, 1);
      cyc(1, 1, 0, 1, 0, 1);
      check("start_while_busy", {16'b0, rem16}, 5);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 1);

      // Asynchronous reset in the middle of a transfer.
      cyc(1, 5, 0, 1, 0, 1);
      cyc(0, 0, 0, 1, 1, 1);
      check("pre_reset_remaining", {16'b0, rem16}, 5);
      #2;
      do_reset();
      cyc(0, 0, 0, 1, 1, 1);
      check("no_done_after_reset", {30'b0, done16, busy16}, 0);

      // xfer_count=15: the 4-bit instance must run 16 transfers without wrapping.
      done_cnt4 = 0;
      cyc(1, 15, 0, 1, 0, 1);
      for (int i = 0; i < 16; i++) begin
         cyc(0, 0, 0, 1, 1, 1);
         cyc(0, 0, 0, 1, 0, 1);
         if (i == 14) check("w4_not_done_at_15", {27'b0, done4, rem4}, 0);
         if (i == 15) check("w4_done_at_16", {31'b0, done4}, 1);
      end
      cyc(0, 0, 0, 1, 0, 1);
      check("w4_done_count", done_cnt4, 1);

      // Randomised traffic.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
         end else begin
            cyc($urandom_range(0, 11) == 0,
                ($urandom_range(0, 7) == 0) ? 32'hFFFF : $urandom_range(0, 12),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), $urandom_range(0, 29) != 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
